scytale_decryption_ex: RTL and testbench

Second-generation scytale decryptor for the message-decryption pipeline. It buffers an incoming character stream until `START_DECRYPTION_TOKEN` arrives, then replays the buffer in scytale (column-major) order. Outputs use a valid/ready handshake with backpressure. The key is sampled at the token, and malformed messages (bad key, length mismatch, overflow) are reported on a dedicated error pulse instead of producing garbage.

---
 rtl/scytale_decryption_ex.sv | 161 ++++++++++++++++
 tb/tb_scytale_decryption_ex.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scytale_decryption_ex.sv
// scytale_decryption_ex: buffers a character stream until the start token, then
// replays it in scytale (column-major) order over a valid/ready output.
// Malformed messages are rejected with a one-cycle err_o pulse.
// Optional feature macro: SCYTALE_PAD_EN (accept short messages, fill with PAD_CHAR).
module scytale_decryption_ex #(
    parameter int                   D_WIDTH                = 8,
    parameter int                   KEY_WIDTH              = 8,
    parameter int                   MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = 'hFA,
    parameter logic [D_WIDTH-1:0]   PAD_CHAR               = 'h20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy,
    output logic                 err_o
);

    localparam int IW = $clog2(MAX_NOF_CHARS + 1);
    localparam int LW = 2 * KEY_WIDTH;

    typedef enum logic [1:0] {COLLECT, DECODE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [D_WIDTH-1:0] mem [MAX_NOF_CHARS];
    logic [IW-1:0]      count;
    logic               ovf;

    // Latched key and message geometry. An accepted message has L <= MAX,
    // so kN, kM and L all fit in the buffer index width.
    logic [IW-1:0]      kn, km, len;
    logic [IW-1:0]      row, col, src, out_cnt;

    logic [LW-1:0]      l_in;
    logic               is_tok, full, bad_len, msg_err;
    logic               load, last_load, fin;
    logic [D_WIDTH-1:0] char_nxt;

    // Token decode and message validation, evaluated against the live key inputs
    always_comb begin
        is_tok = valid_i && (data_i == START_DECRYPTION_TOKEN);
        full   = 32'(count) >= MAX_NOF_CHARS;
        l_in   = LW'(key_N) * LW'(key_M);
`ifdef SCYTALE_PAD_EN
        bad_len = 32'(count) > 32'(l_in);
`else
        bad_len = 32'(count) != 32'(l_in);
`endif
        msg_err = ovf || (count == '0) || (key_N == '0) || (key_M == '0) ||
                  (32'(l_in) > MAX_NOF_CHARS) || bad_len;
    end

    // Output-side control: load a new char whenever the output register is free
    always_comb begin
        load      = (state == DECODE) && (!valid_o || ready_i);
        last_load = load && (out_cnt == len - IW'(1));
        fin       = (state == DRAIN) && valid_o && ready_i;
        char_nxt  = mem[src];
`ifdef SCYTALE_PAD_EN
        if (src >= count) char_nxt = PAD_CHAR;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (is_tok && !msg_err) state_nxt = DECODE;
            DECODE:  if (last_load)          state_nxt = DRAIN;
            DRAIN:   if (fin)                state_nxt = COLLECT;
            default:                         state_nxt = COLLECT;
        endcase
    end

    // Character buffer; contents need no reset
    always_ff @(posedge clk) begin
        if (state == COLLECT && valid_i && !is_tok && !full) mem[count] <= data_i;
    end

    // Datapath: collection counters, key latch, scytale walk and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            busy    <= 1'b0;
            err_o   <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
            kn      <= '0;
            km      <= '0;
            len     <= '0;
            row     <= '0;
            col     <= '0;
            src     <= '0;
            out_cnt <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                COLLECT: begin
                    if (is_tok) begin
                        kn  <= IW'(key_N);
                        km  <= IW'(key_M);
                        len <= IW'(l_in);
                        if (msg_err) begin
                            err_o <= 1'b1;
                            count <= '0;
                            ovf   <= 1'b0;
                        end else begin
                            row     <= '0;
                            col     <= '0;
                            src     <= '0;
                            out_cnt <= '0;
                        end
                    end else if (valid_i) begin
                        if (!full) count <= count + IW'(1);
                        else       ovf   <= 1'b1;
                    end
                end
                DECODE: begin
                    if (load) begin
                        data_o  <= char_nxt;
                        valid_o <= 1'b1;
                        busy    <= 1'b1;
                        out_cnt <= out_cnt + IW'(1);
                        // Walk down a column (stride kN); on wrap start the next column
                        if (row == km - IW'(1)) begin
                            row <= '0;
                            col <= col + IW'(1);
                            src <= col + IW'(1);
                        end else begin
                            row <= row + IW'(1);
                            src <= src + kn;
                        end
                    end
                end
                DRAIN: begin
                    if (fin) begin
                        valid_o <= 1'b0;
                        busy    <= 1'b0;
                        count   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scytale_decryption_ex.sv
// Self-checking bench for scytale_decryption_ex: directed scenarios plus
// randomized messages compared against an index-arithmetic reference model.
module tb_scytale_decryption_ex;

    localparam int         MAX = 50;
    localparam logic [7:0] TOK = 8'hFA;
    localparam logic [7:0] PAD = 8'h20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N, key_M;
    logic [7:0] data_o;
    logic       valid_o, ready_i, busy, err_o;

    int checks = 0;
    int failures = 0;

    logic [7:0] msg_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         exp_err;
    int         err_cnt;
    int         rdy_mode;
    int         rcyc;
    bit         stall_prev;
    logic [7:0] stall_data;

    scytale_decryption_ex dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key_N   (key_N),
        .key_M   (key_M),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy    (busy),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    // One clock: update ready after the edge, then observe outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        rcyc++;
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = (rcyc % 3 == 0);
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== stall_data) begin
                    failures++;
                    $display("FAIL stall_hold: valid_o=%b data_o=%h required valid_o=1 data_o=%h",
                             valid_o, data_o, stall_data);
                end
            end
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (err_o) err_cnt++;
            stall_prev = valid_o && !ready_i;
            stall_data = data_o;
        end
    endtask

    task automatic load_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    // Reference: output j takes source (j mod M)*N + (j div M).
    task automatic build_exp(input int n, input int m);
        int sz, l, s;
        sz = msg_q.size();
        l  = n * m;
        exp_q.delete();
        exp_err = (sz == 0) || (sz > MAX) || (n == 0) || (m == 0) || (l > MAX);
`ifdef SCYTALE_PAD_EN
        exp_err = exp_err || (sz > l);
`else
        exp_err = exp_err || (sz != l);
`endif
        if (!exp_err) begin
            for (int j = 0; j < l; j++) begin
                s = (j % m) * n + (j / m);
                exp_q.push_back(s < sz ? msg_q[s] : PAD);
            end
        end
    endtask

    task automatic send_msg(input int n, input int m);
        for (int i = 0; i < msg_q.size(); i++) begin
            valid_i = 1'b1;
            data_i  = msg_q[i];
            tick();
        end
        valid_i = 1'b1;
        data_i  = TOK;
        key_N   = 8'(n);
        key_M   = 8'(m);
        tick();
        valid_i = 1'b0;
        data_i  = 8'($urandom);
        key_N   = 8'($urandom);
        key_M   = 8'($urandom);
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (!(got_q.size() >= exp_q.size() && !busy) && cyc < 1000) begin
            tick();
            cyc++;
        end
        if (cyc >= 1000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d chars required %0d", name, got_q.size(), exp_q.size());
        end
        repeat (4) tick();
    endtask

    task automatic compare_out(input string name);
        checks++;
        if (err_cnt !== int'(exp_err)) begin
            failures++;
            $display("FAIL %s_err_count: got %0d required %0d", name, err_cnt, int'(exp_err));
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_length: got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_char%0d: got %h required %h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic run_msg(input string name, input int n, input int m, input int mode);
        rdy_mode = mode;
        got_q.delete();
        err_cnt = 0;
        build_exp(n, m);
        send_msg(n, m);
        if (exp_err) begin
            checks++;
            if (err_o !== 1'b1) begin
                failures++;
                $display("FAIL %s_err_pulse: err_o=%b required 1", name, err_o);
            end
            tick();
            checks++;
            if (err_o !== 1'b0) begin
                failures++;
                $display("FAIL %s_err_width: err_o=%b required 0", name, err_o);
            end
            repeat (6) tick();
        end else begin
            wait_done(name);
        end
        compare_out(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; data_i = '0; key_N = '0; key_M = '0;
        rdy_mode = 0;
        repeat (3) tick();
        checks++;
        if ({data_o, valid_o, busy, err_o} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: data_o=%h valid_o=%b busy=%b err_o=%b required all 0",
                     data_o, valid_o, busy, err_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        rdy_mode = 0;
        load_str("ABCDEF");
        build_exp(2, 3);
        got_q.delete();
        err_cnt = 0;
        send_msg(2, 3);
        checks++;
        if (valid_o !== 1'b0 || busy !== 1'b0 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_token_cycle: valid_o=%b busy=%b err_o=%b required 0 0 0",
                     valid_o, busy, err_o);
        end
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if (valid_o !== 1'b1 || busy !== 1'b1 || data_o !== exp_q[j]) begin
                failures++;
                $display("FAIL basic_out%0d: valid_o=%b busy=%b data_o=%h required 1 1 %h",
                         j, valid_o, busy, data_o, exp_q[j]);
            end
        end
        tick();
        checks++;
        if (valid_o !== 1'b0 || busy !== 1'b0 || err_cnt != 0) begin
            failures++;
            $display("FAIL basic_done: valid_o=%b busy=%b errs=%0d required 0 0 0",
                     valid_o, busy, err_cnt);
        end
        repeat (2) tick();
    endtask

    task automatic test_stall();
        load_str("ABCDEF");
        run_msg("stall", 2, 3, 1);
    endtask

    task automatic test_short();
        load_str("ABCDE");
        run_msg("short", 2, 3, 0);
        load_str("ABCDEF");
        run_msg("after_short", 2, 3, 0);
    endtask

    task automatic test_errors();
        msg_q.delete();
        for (int i = 0; i < 51; i++) msg_q.push_back(8'h41 + 8'(i % 26));
        run_msg("overflow", 5, 10, 0);
        load_str("AB");
        run_msg("key_n_zero", 0, 3, 0);
        run_msg("key_m_zero", 2, 0, 0);
        load_str("ABCDEF");
        run_msg("l_too_big", 8, 8, 0);
        load_str("");
        run_msg("empty", 1, 1, 0);
        load_str("WXYZ");
        run_msg("after_errors", 4, 1, 2);
    endtask

    task automatic test_reset_mid();
        rdy_mode = 0;
        load_str("ABCDEF");
        send_msg(2, 3);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({data_o, valid_o, busy, err_o} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: data_o=%h valid_o=%b busy=%b err_o=%b required all 0",
                     data_o, valid_o, busy, err_o);
        end
        rst_n = 1'b1;
        tick();
        load_str("ABCD");
        run_msg("after_reset", 2, 2, 0);
    endtask

    task automatic test_ignore();
        rdy_mode = 1;
        load_str("ABCDEF");
        build_exp(2, 3);
        got_q.delete();
        err_cnt = 0;
        send_msg(2, 3);
        repeat (2) tick();
        valid_i = 1'b1; data_i = "X"; tick();
        data_i = "Y"; tick();
        data_i = TOK; key_N = 8'd1; key_M = 8'd1; tick();
        valid_i = 1'b0;
        wait_done("ignore");
        repeat (10) tick();
        compare_out("ignore");
        load_str("ABCD");
        run_msg("after_ignore", 2, 2, 0);
    endtask

    task automatic test_random();
        int n, m, l, sz;
        logic [7:0] c;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 6);
            m = $urandom_range(1, 6);
            l = n * m;
            sz = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l + 1) : l;
            msg_q.delete();
            for (int i = 0; i < sz; i++) begin
                c = 8'($urandom_range(0, 255));
                if (c == TOK) c = 8'h41;
                msg_q.push_back(c);
            end
            run_msg($sformatf("rand%0d", it), n, m, $urandom_range(0, 2));
        end
    endtask

    initial begin
        rcyc = 0;
        stall_prev = 1'b0;
        ready_i = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_short();
        test_errors();
        test_reset_mid();
        test_ignore();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
